// File: rtl/mda_video_pipe_if.sv
// Pixel-domain video bus for mda_video_pipe: raw MDA timing/attribute inputs
// and the colour-expanded, delayed outputs.
interface mda_video_pipe_if #(
    parameter int RED_W = 6,
    parameter int GRN_W = 7,
    parameter int BLU_W = 6
);
    logic             video;
    logic             intensity;
    logic             hsync;
    logic             vsync;
    logic             display_enable;
    logic [RED_W-1:0] red;
    logic [GRN_W-1:0] green;
    logic [BLU_W-1:0] blue;
    logic             hs_out;
    logic             vs_out;
    logic             de_out;

    modport master (
        output video, intensity, hsync, vsync, display_enable,
        input  red, green, blue, hs_out, vs_out, de_out
    );

    modport slave (
        input  video, intensity, hsync, vsync, display_enable,
        output red, green, blue, hs_out, vs_out, de_out
    );
endinterface

// File: rtl/mda_video_pipe.sv
// MDA monochrome video to RGB pipe with switch-selected palette and blink timer.
// Optional macro MDA_SCANLINE_EN halves the brightness of odd scan lines.
module mda_video_pipe #(
    parameter int          RED_W      = 6,
    parameter int          GRN_W      = 7,
    parameter int          BLU_W      = 6,
    parameter int          PIPE_DLY   = 2,
    parameter logic [23:0] BLINK_MAX  = 24'd9100000,
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            switch2,
    input  logic            switch3,
    mda_video_pipe_if.slave bus,
    output logic            blink
);

    logic [1:0]  sw_meta;
    logic [1:0]  sw_sync;
    logic [1:0]  sw_cand;
    logic [15:0] deb_cnt;
    logic [1:0]  sw_deb;
    logic [1:0]  pal;
    logic        vsync_q;
    logic        vs_rise;
    logic [23:0] blink_cnt;
    logic        odd_line;
    logic        pix_on;

    logic [1:0] lvl_r;
    logic [1:0] lvl_g;
    logic [1:0] lvl_b;

    logic [RED_W-1:0] pat_r;
    logic [GRN_W-1:0] pat_g;
    logic [BLU_W-1:0] pat_b;
    logic [RED_W-1:0] red_in;
    logic [GRN_W-1:0] green_in;
    logic [BLU_W-1:0] blue_in;

    logic [RED_W-1:0] red_dly   [PIPE_DLY];
    logic [GRN_W-1:0] green_dly [PIPE_DLY];
    logic [BLU_W-1:0] blue_dly  [PIPE_DLY];
    logic [PIPE_DLY-1:0] hs_dly;
    logic [PIPE_DLY-1:0] vs_dly;
    logic [PIPE_DLY-1:0] de_dly;

    assign vs_rise = bus.vsync & ~vsync_q;
    assign pix_on  = bus.video & bus.display_enable;

    // The candidate only becomes the debounced value after it has held steady
    // in the synchronized domain for the full stability window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta <= 2'b00;
            sw_sync <= 2'b00;
            sw_cand <= 2'b00;
            deb_cnt <= 16'd0;
            sw_deb  <= 2'b00;
            pal     <= 2'b00;
            vsync_q <= 1'b0;
        end else begin
            sw_meta <= {switch3, switch2};
            sw_sync <= sw_meta;
            vsync_q <= bus.vsync;
            if (sw_sync != sw_cand) begin
                sw_cand <= sw_sync;
                deb_cnt <= 16'd0;
            end else if (deb_cnt == DEB_CYCLES - 16'd1) begin
                sw_deb <= sw_cand;
            end else begin
                deb_cnt <= deb_cnt + 16'd1;
            end
            if (vs_rise) begin
                pal <= sw_deb;
            end
        end
    end

`ifdef MDA_SCANLINE_EN
    logic hsync_q;
    logic line_par;

    // Only the parity of the line count is consumed, so the counter is one bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q  <= 1'b0;
            line_par <= 1'b0;
        end else begin
            hsync_q <= bus.hsync;
            if (vs_rise) begin
                line_par <= 1'b0;
            end else if (bus.hsync && !hsync_q) begin
                line_par <= ~line_par;
            end
        end
    end

    assign odd_line = line_par;
`else
    assign odd_line = 1'b0;
`endif

    always_comb begin
        lvl_r = 2'd0;
        lvl_g = 2'd0;
        lvl_b = 2'd0;
        case (pal)
            2'b00: begin
                if (bus.intensity) {lvl_r, lvl_g, lvl_b} = {2'd1, 2'd3, 2'd1};
                else               {lvl_r, lvl_g, lvl_b} = {2'd0, 2'd2, 2'd0};
            end
            2'b01: begin
                if (bus.intensity) {lvl_r, lvl_g, lvl_b} = {2'd3, 2'd2, 2'd0};
                else               {lvl_r, lvl_g, lvl_b} = {2'd2, 2'd1, 2'd0};
            end
            2'b10: begin
                if (bus.intensity) {lvl_r, lvl_g, lvl_b} = {2'd3, 2'd3, 2'd3};
                else               {lvl_r, lvl_g, lvl_b} = {2'd2, 2'd2, 2'd2};
            end
            default: begin
                if (bus.intensity) {lvl_r, lvl_g, lvl_b} = {2'd3, 2'd3, 2'd3};
                else               {lvl_r, lvl_g, lvl_b} = {2'd1, 2'd1, 2'd1};
            end
        endcase
    end

    // Level code repeated MSB-first across the component width.
    for (genvar i = 0; i < RED_W; i++) begin : g_pat_r
        assign pat_r[RED_W-1-i] = lvl_r[1 - (i % 2)];
    end
    for (genvar i = 0; i < GRN_W; i++) begin : g_pat_g
        assign pat_g[GRN_W-1-i] = lvl_g[1 - (i % 2)];
    end
    for (genvar i = 0; i < BLU_W; i++) begin : g_pat_b
        assign pat_b[BLU_W-1-i] = lvl_b[1 - (i % 2)];
    end

    always_comb begin
        red_in   = '0;
        green_in = '0;
        blue_in  = '0;
        if (pix_on) begin
            red_in   = pat_r;
            green_in = pat_g;
            blue_in  = pat_b;
            if (odd_line) begin
                red_in   = pat_r >> 1;
                green_in = pat_g >> 1;
                blue_in  = pat_b >> 1;
            end
        end
    end

    // Colour and timing share one delay line so they stay cycle-aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                red_dly[i]   <= '0;
                green_dly[i] <= '0;
                blue_dly[i]  <= '0;
            end
            hs_dly <= '0;
            vs_dly <= '0;
            de_dly <= '0;
        end else begin
            red_dly[0]   <= red_in;
            green_dly[0] <= green_in;
            blue_dly[0]  <= blue_in;
            hs_dly[0]    <= bus.hsync;
            vs_dly[0]    <= bus.vsync;
            de_dly[0]    <= bus.display_enable;
            for (int i = 1; i < PIPE_DLY; i++) begin
                red_dly[i]   <= red_dly[i-1];
                green_dly[i] <= green_dly[i-1];
                blue_dly[i]  <= blue_dly[i-1];
                hs_dly[i]    <= hs_dly[i-1];
                vs_dly[i]    <= vs_dly[i-1];
                de_dly[i]    <= de_dly[i-1];
            end
        end
    end

    assign bus.red    = red_dly[PIPE_DLY-1];
    assign bus.green  = green_dly[PIPE_DLY-1];
    assign bus.blue   = blue_dly[PIPE_DLY-1];
    assign bus.de_out = de_dly[PIPE_DLY-1];
    assign bus.hs_out = ~(hs_dly[PIPE_DLY-1] ^ HS_POL);
    assign bus.vs_out = ~(vs_dly[PIPE_DLY-1] ^ VS_POL);

    // Blink phase flips on the same edge the counter wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= 24'd0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_MAX - 24'd1) begin
            blink_cnt <= 24'd0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 24'd1;
        end
    end

endmodule

// File: doc/mda_video_pipe.md
MDA_VIDEO_PIPE -- requirements
Module: mda_video_pipe

Interface
REQ-001 SHALL have parameter RED_W, default 6, red output width (1..8).
REQ-002 SHALL have parameter GRN_W, default 7, green output width (1..8).
REQ-003 SHALL have parameter BLU_W, default 6, blue output width (1..8).
REQ-004 SHALL have parameter PIPE_DLY, default 2, input-to-output latency in clocks (1..8).
REQ-005 SHALL have parameter BLINK_MAX, default 24'd9100000, blink half-period in clocks.
REQ-006 SHALL have parameter DEB_CYCLES, default 16'd50000, switch debounce stability count.
REQ-007 SHALL have parameters HS_POL and VS_POL, default 0, output sync active level (1 = active-high).
REQ-008 SHALL have ports: clk in 1 pixel clock; reset in 1 synchronous active-high reset; one clock, reset is synchronous and active-high.
REQ-009 SHALL have ports: video in 1 pixel on; intensity in 1 bright pixel; hsync in 1 active-high; vsync in 1 active-high; display_enable in 1 active region.
REQ-010 SHALL have ports: switch2 in 1 async; switch3 in 1 async (palette select).
REQ-011 SHALL have ports: red out RED_W; green out GRN_W; blue out BLU_W; hs_out out 1; vs_out out 1; de_out out 1; blink out 1 (cursor/attribute blink phase).

Function
REQ-012 SHALL pass switch2/switch3 through a 2-flop synchronizer, then accept the 2-bit value {switch3,switch2} as debounced only after it is unchanged for DEB_CYCLES consecutive clocks.
REQ-013 SHALL load the debounced value into palette register pal only on the clock where synchronized vsync is 1 and was 0 on the previous clock; never mid-frame.
REQ-014 SHALL map 2-bit level code L to a W-bit component by repeating L MSB-first and truncating to W bits (W=6, L=2 -> 101010; W=7, L=3 -> 1111111).
REQ-015 SHALL use levels (R,G,B) normal/intense: pal=00 green (0,2,0)/(1,3,1); 01 amber (2,1,0)/(3,2,0); 10 white (2,2,2)/(3,3,3); 11 dim white (1,1,1)/(3,3,3).
REQ-016 SHALL output all components 0 when display_enable=0 or video=0, regardless of intensity.
REQ-017 SHALL delay RGB, hsync, vsync, display_enable by exactly PIPE_DLY clocks, all aligned; one pixel in per clock, no stalls.
REQ-018 SHALL drive hs_out = delayed hsync XNOR HS_POL inverted as needed so active state equals HS_POL; likewise vs_out with VS_POL.
REQ-019 SHALL run a 24-bit blink counter incrementing every clock; on reaching BLINK_MAX-1 it SHALL wrap to 0 and toggle blink on that same edge.
REQ-020 SHALL treat a palette change pending during reset as discarded.

Reset
REQ-021 On reset=1 at a clk edge: red/green/blue=0, de_out=0, hs_out=~HS_POL, vs_out=~VS_POL, blink=0, blink counter=0, pal=00, debounce counter=0, all delay stages cleared (hsync/vsync/de stages=0).
REQ-022 Reset asserted mid-frame SHALL take effect on the next edge; outputs resume with new input after PIPE_DLY clocks after release.

Configuration
REQ-023 Macro MDA_SCANLINE_EN: when defined, SHALL count hsync rising edges since last vsync rising edge (line counter reset to 0 at vsync rise and reset), and on odd lines right-shift every nonzero component by 1 before the delay line.
REQ-024 Without MDA_SCANLINE_EN, no line counter SHALL exist and all lines use REQ-015 values unmodified.

Verification
REQ-025 Reset, then video=1,intensity=0,de=1,pal=00, defaults -> after 2 clocks red=0, green=7'b1010101, blue=0.
REQ-026 Set switches to 01 stable DEB_CYCLES=4, no vsync rise -> palette stays green; one vsync rise -> next pixel video=1,intensity=1 gives red=6'b111111, green=7'b1010101, blue=0.
REQ-027 Switch glitch shorter than DEB_CYCLES across a vsync rise -> pal unchanged.
REQ-028 BLINK_MAX=5 -> blink toggles every 5 clocks after reset (edges at clocks 5,10,15).
REQ-029 PIPE_DLY=4, HS_POL=0, single-clock hsync pulse -> hs_out low for exactly one clock, 4 clocks later; de=0 with video=1 -> RGB=0.
REQ-030 MDA_SCANLINE_EN defined, pal=10 intense on line 1 -> components 6'b011111/7'b0111111/6'b011111; line 0 -> all ones.
